// File: rtl/ddr_line_arbiter.sv
// Two-master Wishbone line arbiter (DCache = m0, ICache = m1) in front of a single DDR controller port.
// Holds ownership for a whole cyc burst and recovers a stalled strobe with a forced ack.
module ddr_line_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  // master 0 (DCache)
  input  logic [31:0]  m0_addr,
  input  logic [511:0] m0_dout,
  input  logic [63:0]  m0_dm,
  input  logic         m0_cyc,
  input  logic         m0_stb,
  input  logic         m0_we,
  output logic         m0_ack,
  output logic [511:0] m0_din,
  // master 1 (ICache)
  input  logic [31:0]  m1_addr,
  input  logic [511:0] m1_dout,
  input  logic [63:0]  m1_dm,
  input  logic         m1_cyc,
  input  logic         m1_stb,
  input  logic         m1_we,
  output logic         m1_ack,
  output logic [511:0] m1_din,
  // slave (DDR controller)
  output logic [31:0]  s_addr,
  output logic [511:0] s_dout,
  output logic [63:0]  s_dm,
  output logic         s_cyc,
  output logic         s_stb,
  output logic         s_we,
  input  logic         s_ack,
  input  logic [511:0] s_din,
  output logic         timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state, state_nxt;
  logic            last_grant;   // 1: m1 was granted last, so m0 wins the next tie
  logic [CW-1:0]   stall_cnt;
  logic            stb_raw;
  logic            force_ack;

  assign m0_din = s_din;
  assign m1_din = s_din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == OWN0) last_grant <= 1'b0;
      if (state == IDLE && state_nxt == OWN1) last_grant <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    s_addr    = '0;
    s_dout    = '0;
    s_dm      = '0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    stb_raw   = 1'b0;
    force_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_nxt = last_grant ? OWN0 : OWN1;
        else if (m0_cyc)      state_nxt = OWN0;
        else if (m1_cyc)      state_nxt = OWN1;
      end
      OWN0: begin
        s_addr    = m0_addr;
        s_dout    = m0_dout;
        s_dm      = m0_dm;
        s_cyc     = m0_cyc;
        s_we      = m0_we;
        stb_raw   = m0_stb;
        // a real ack in the terminal stall cycle wins over the forced one
        force_ack = m0_stb && !s_ack && (stall_cnt == CNT_MAX);
        s_stb     = m0_stb && !force_ack;
        m0_ack    = s_ack || force_ack;
        if (!m0_cyc) state_nxt = IDLE;
      end
      OWN1: begin
        s_addr    = m1_addr;
        s_dout    = m1_dout;
        s_dm      = m1_dm;
        s_cyc     = m1_cyc;
        s_we      = m1_we;
        stb_raw   = m1_stb;
        force_ack = m1_stb && !s_ack && (stall_cnt == CNT_MAX);
        s_stb     = m1_stb && !force_ack;
        m1_ack    = s_ack || force_ack;
        if (!m1_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state == IDLE || !stb_raw || s_ack || force_ack) stall_cnt <= '0;
      else                                                 stall_cnt <= stall_cnt + CNT_ONE;
      if (force_ack) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_line_arbiter.sv
// Directed bench for ddr_line_arbiter: grant order, burst atomicity, stall timeout and reset abort.
module tb_ddr_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  m0_addr, m1_addr, s_addr;
  logic [511:0] m0_dout, m1_dout, s_dout, m0_din, m1_din, s_din;
  logic [63:0]  m0_dm, m1_dm, s_dm;
  logic         m0_cyc, m0_stb, m0_we, m0_ack;
  logic         m1_cyc, m1_stb, m1_we, m1_ack;
  logic         s_cyc, s_stb, s_we, s_ack, timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ddr_line_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_dm(m0_dm),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_ack(m0_ack), .m0_din(m0_din),
    .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_dm(m1_dm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_ack(m1_ack), .m1_din(m1_din),
    .s_addr(s_addr), .s_dout(s_dout), .s_dm(s_dm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack), .s_din(s_din),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    m0_addr = 32'h0001_2340; m1_addr = 32'h0abc_def0;
    m0_dout = {16{32'h0d0d_0d0d}}; m1_dout = {16{32'h1e1e_1e1e}};
    m0_dm   = 64'h0000_0000_ffff_ffff; m1_dm = 64'hffff_0000_ffff_0000;
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0; s_din = {16{32'hcafe_f00d}};
    #12;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single m0 read: one arbitration cycle, then passthrough
    m0_cyc = 1; m0_stb = 1;
    #1;
    chk("arb_idle_s_cyc", s_cyc, 0);
    chk("arb_idle_s_addr", s_addr, 0);
    tick();
    chk("own0_s_cyc", s_cyc, 1);
    chk("own0_s_addr", s_addr, 32'h0001_2340);
    chk("own0_s_dout", s_dout, {16{32'h0d0d_0d0d}});
    chk("own0_s_dm", s_dm, 64'h0000_0000_ffff_ffff);
    s_ack = 1;
    #1;
    chk("own0_m0_ack", m0_ack, 1);
    chk("own0_m1_ack", m1_ack, 0);
    chk("din_bcast_m0", m0_din, {16{32'hcafe_f00d}});
    chk("din_bcast_m1", m1_din, {16{32'hcafe_f00d}});
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();

    // tie after reset goes to m0; release with re-request goes to m1
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("tie_s_addr_m0", s_addr, 32'h0001_2340);
    m0_cyc = 0;
    tick();
    m0_cyc = 1;
    #1;
    chk("rel_idle_s_cyc", s_cyc, 0);
    tick();
    chk("rerq_s_addr_m1", s_addr, 32'h0abc_def0);
    chk("rerq_s_cyc", s_cyc, 1);

    // m0 read then writeback stays atomic while m1 waits
    m1_cyc = 0;
    tick();
    tick();
    chk("wb_own0_addr", s_addr, 32'h0001_2340);
    m1_cyc = 1; m0_stb = 1; m0_we = 0; s_ack = 1;
    #1;
    chk("wb_rd_ack", m0_ack, 1);
    chk("wb_rd_we", s_we, 0);
    tick();
    m0_we = 1;
    #1;
    chk("wb_wr_we", s_we, 1);
    chk("wb_wr_ack", m0_ack, 1);
    chk("wb_wr_m1_ack", m1_ack, 0);
    tick();
    s_ack = 0; m0_stb = 0; m0_we = 0;
    tick();
    chk("wb_hold_addr", s_addr, 32'h0001_2340);
    m0_cyc = 0;
    tick();
    chk("wb_idle_s_cyc", s_cyc, 0);
    tick();
    chk("wb_m1_addr", s_addr, 32'h0abc_def0);

    // stall ended by a real ack in the terminal cycle: no forced ack
    m1_stb = 1;
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk("prec_stall_stb", s_stb, 1);
      tick();
    end
    s_ack = 1;
    #1;
    chk("prec_m1_ack", m1_ack, 1);
    chk("prec_s_stb", s_stb, 1);
    tick();
    s_ack = 0;
    #1;
    chk("prec_timeout", timeout, 0);

    // sixteen stalled cycles force an ack
    for (int k = 1; k <= 15; k++) begin
      chk("to_stall_ack", m1_ack, 0);
      tick();
    end
    chk("to_forced_ack", m1_ack, 1);
    chk("to_forced_stb", s_stb, 0);
    chk("to_m0_ack", m0_ack, 0);
    chk("to_before_flag", timeout, 0);
    tick();
    chk("to_flag_set", timeout, 1);
    chk("to_after_ack", m1_ack, 0);
    chk("to_after_stb", s_stb, 1);
    s_ack = 1;
    #1;
    chk("to_normal_ack", m1_ack, 1);
    tick();
    s_ack = 0; m1_stb = 0; m1_cyc = 0;
    tick();
    chk("to_sticky", timeout, 1);

    // owner drops cyc with stb pending; late ack is dropped
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("late_own0", s_cyc, 1);
    m0_cyc = 0;
    tick();
    s_ack = 1;
    #1;
    chk("late_m0_ack", m0_ack, 0);
    chk("late_m1_ack", m1_ack, 0);
    chk("late_s_cyc", s_cyc, 0);
    chk("late_s_stb", s_stb, 0);
    tick();
    s_ack = 0; m0_stb = 0;

    // reset mid-transfer in OWN1
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("rab_own1", s_cyc, 1);
    #2;
    rst = 1'b0; s_ack = 1;
    #1;
    chk("rab_s_cyc", s_cyc, 0);
    chk("rab_m1_ack", m1_ack, 0);
    chk("rab_s_stb", s_stb, 0);
    chk("rab_timeout", timeout, 0);
    s_ack = 0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    m0_cyc = 1;
    tick();
    tick();
    chk("rab_tie_m0", s_addr, 32'h0001_2340);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_line_arbiter.md
DDR_LINE_ARBITER -- requirements
Module: ddr_line_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: maximum number of stalled strobe cycles before a forced ack.
REQ-002 SHALL have port clk, input, 1 bit: the DDR-side clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports m0_addr/m0_dout/m0_dm, input, 32/512/64 bits: master 0 (DCache) Wishbone address, write data and write mask.
REQ-005 SHALL have ports m0_cyc/m0_stb/m0_we, input, 1 bit each: master 0 Wishbone cycle, strobe and write-enable.
REQ-006 SHALL have ports m0_ack, output, 1 bit, and m0_din, output, 512 bits: master 0 acknowledge and read data.
REQ-007 SHALL have ports m1_* (master 1, ICache) identical in name pattern, width and direction to the m0_* ports.
REQ-008 SHALL have ports s_addr/s_dout/s_dm, output, 32/512/64 bits: slave-side (DDR controller) address, write data and write mask.
REQ-009 SHALL have ports s_cyc/s_stb/s_we, output, 1 bit each, and s_ack, input, 1 bit, and s_din, input, 512 bits: slave-side Wishbone controls and return path.
REQ-010 SHALL have port timeout, output, 1 bit: sticky bus-timeout error flag.

Function
REQ-011 SHALL implement states IDLE, OWN0 and OWN1 in a single FSM.
REQ-012 In IDLE: m0_cyc only -> OWN0; m1_cyc only -> OWN1; both -> the master not granted last; neither -> stay in IDLE.
REQ-013 Register last_grant SHALL update on every grant; its reset value selects m0 as the winner of the first tie.
REQ-014 Arbitration SHALL add one cycle: a master's cyc sampled in IDLE produces s_cyc on the following cycle.
REQ-015 In OWNx: s_cyc = mx_cyc, s_stb = mx_stb, s_we = mx_we, s_addr/s_dout/s_dm = master x signals (combinational mux).
REQ-016 In IDLE: s_cyc, s_stb and s_we SHALL be 0; s_addr, s_dout and s_dm SHALL be 0.
REQ-017 The grant SHALL be held while the owner keeps cyc high, across any number of stb/ack beats, so DCache read-then-writeback sequences stay atomic.
REQ-018 Owner deasserts cyc -> IDLE next cycle, even if stb is high or an ack is outstanding; a late s_ack in IDLE SHALL be dropped.
REQ-019 m0_din and m1_din SHALL both equal s_din (broadcast).
REQ-020 mx_ack SHALL equal s_ack only while in OWNx; the non-owner ack SHALL always be 0.
REQ-021 Stall counter (width ceil(log2(TIMEOUT+1))) SHALL increment each cycle with s_stb=1 and s_ack=0, and clear on s_ack, on s_stb=0, or in IDLE.
REQ-022 When the counter equals TIMEOUT:
- the owner's ack SHALL be forced to 1 for exactly one cycle;
- s_stb SHALL be forced to 0 in that cycle;
- the counter SHALL clear;
- timeout SHALL be set to 1.
REQ-023 timeout SHALL stay 1 until reset; later transactions SHALL proceed normally.
REQ-024 s_ack arriving in the same cycle the counter reaches TIMEOUT SHALL take precedence: normal ack, no forced ack, timeout unchanged.
REQ-025 A new request from the just-released master in the IDLE cycle after release SHALL still lose to a pending request from the other master.

Reset
REQ-026 rst=0 SHALL immediately and asynchronously force:
- state = IDLE, last_grant = m1, counter = 0, timeout = 0;
- s_cyc = s_stb = s_we = 0, m0_ack = m1_ack = 0.
REQ-027 Reset asserted mid-transaction SHALL abort the transfer without generating an ack; after release, arbitration restarts from IDLE.

Verification
REQ-028 m0_cyc=m0_stb=1, m0_addr=0x00012340 -> s_cyc=1 with s_addr=0x00012340 one cycle later; s_ack pulse -> m0_ack=1 and m1_ack=0 in the same cycle.
REQ-029 m0_cyc and m1_cyc rise together after reset -> m0 granted; m0 releases with m1 still requesting and m0 re-requesting -> m1 granted after one IDLE cycle.
REQ-030 m0 holds cyc through a read beat (we=0, ack) then a write beat (we=1, ack) while m1 requests -> no switch to m1 until m0_cyc=0.
REQ-031 TIMEOUT=15, owner stb high, s_ack held 0 -> forced owner ack on the 16th stalled cycle, with s_stb=0 in that cycle; timeout=1 and stays 1 through a following normal transaction.
REQ-032 rst pulsed low while in OWN1 with stb high -> s_cyc=0 and m1_ack=0 immediately; a tie after reset release -> m0 granted.
REQ-033 Owner drops cyc with stb pending; s_ack arrives the next cycle -> neither mx_ack asserts, state is IDLE.
